// File: rtl/truth_table_sweeper.sv
// Programmable N_IN-input boolean function (truth-table register) with a sweeper that
// streams every (minterm, f) pair and counts the ones. Optional SWEEP_CHECK_EN adds expected-table compare.
module truth_table_sweeper #(
    parameter  int N_IN = 4,
    localparam int TT_W = 2 ** N_IN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tt_load,
    input  logic [TT_W-1:0]   tt_data,
    input  logic              start,
    input  logic [N_IN-1:0]   x,
    output logic              f,
    output logic              busy,
    output logic              sweep_valid,
    output logic [N_IN-1:0]   sweep_in,
    output logic              sweep_out,
    output logic              done,
    output logic [N_IN:0]     ones_cnt
`ifdef SWEEP_CHECK_EN
    ,
    input  logic [TT_W-1:0]   exp_data,
    output logic              mismatch,
    output logic [N_IN-1:0]   first_err
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    // idx carries one extra bit so the last index compare never aliases into a second pass.
    localparam logic [N_IN:0] LAST_IDX = (N_IN + 1)'(TT_W - 1);

    state_t            state, state_nxt;
    logic [N_IN:0]     idx, idx_nxt;
    logic [TT_W-1:0]   tt, tt_nxt;
    logic              f_nxt;
    logic              busy_nxt;
    logic              sweep_valid_nxt;
    logic [N_IN-1:0]   sweep_in_nxt;
    logic              sweep_out_nxt;
    logic              done_nxt;
    logic [N_IN:0]     ones_cnt_nxt;
    logic [N_IN-1:0]   cur;
    logic              cur_bit;

    assign cur     = idx[N_IN-1:0];
    assign cur_bit = tt[cur];

`ifdef SWEEP_CHECK_EN
    logic [TT_W-1:0]   exp_tt, exp_tt_nxt;
    logic              mismatch_nxt;
    logic [N_IN-1:0]   first_err_nxt;
`endif

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt       = state;
        idx_nxt         = idx;
        tt_nxt          = tt;
        f_nxt           = tt[x];
        busy_nxt        = busy;
        sweep_valid_nxt = sweep_valid;
        sweep_in_nxt    = sweep_in;
        sweep_out_nxt   = sweep_out;
        done_nxt        = 1'b0;
        ones_cnt_nxt    = ones_cnt;
`ifdef SWEEP_CHECK_EN
        exp_tt_nxt      = exp_tt;
        mismatch_nxt    = mismatch;
        first_err_nxt   = first_err;
`endif

        case (state)
            IDLE: begin
                sweep_valid_nxt = 1'b0;
                if (tt_load) begin
                    tt_nxt = tt_data;
                end
                if (start) begin
                    state_nxt    = SWEEP;
                    idx_nxt      = '0;
                    ones_cnt_nxt = '0;
                    busy_nxt     = 1'b1;
`ifdef SWEEP_CHECK_EN
                    exp_tt_nxt    = exp_data;
                    mismatch_nxt  = 1'b0;
                    first_err_nxt = '0;
`endif
                end
            end

            SWEEP: begin
                sweep_valid_nxt = 1'b1;
                sweep_in_nxt    = cur;
                sweep_out_nxt   = cur_bit;
                ones_cnt_nxt    = ones_cnt + (N_IN + 1)'(cur_bit);
                idx_nxt         = idx + 1'b1;
                if (idx == LAST_IDX) begin
                    state_nxt = DONE;
                end
`ifdef SWEEP_CHECK_EN
                if (cur_bit != exp_tt[cur]) begin
                    mismatch_nxt = 1'b1;
                    // mismatch is cleared at start, so its old value marks the first miss of this sweep.
                    if (!mismatch) begin
                        first_err_nxt = cur;
                    end
                end
`endif
            end

            DONE: begin
                sweep_valid_nxt = 1'b0;
                done_nxt        = 1'b1;
                busy_nxt        = 1'b0;
                state_nxt       = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            tt          <= '0;
            f           <= 1'b0;
            busy        <= 1'b0;
            sweep_valid <= 1'b0;
            sweep_in    <= '0;
            sweep_out   <= 1'b0;
            done        <= 1'b0;
            ones_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            tt          <= tt_nxt;
            f           <= f_nxt;
            busy        <= busy_nxt;
            sweep_valid <= sweep_valid_nxt;
            sweep_in    <= sweep_in_nxt;
            sweep_out   <= sweep_out_nxt;
            done        <= done_nxt;
            ones_cnt    <= ones_cnt_nxt;
        end
    end

`ifdef SWEEP_CHECK_EN
    // NOTE: exp_tt is left unreset; it is always captured at start before SWEEP reads it.
    always_ff @(posedge clk) begin
        exp_tt <= exp_tt_nxt;
        if (reset) begin
            mismatch  <= 1'b0;
            first_err <= '0;
        end else begin
            mismatch  <= mismatch_nxt;
            first_err <= first_err_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed + randomized bench for truth_table_sweeper (N_IN=4) against a bit-vector reference model.
// The SWEEP_CHECK_EN build is covered when the macro is defined for both files.
module tb_truth_table_sweeper;

    localparam int N_IN = 4;
    localparam int TT_W = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            tt_load;
    logic [TT_W-1:0] tt_data;
    logic            start;
    logic [N_IN-1:0] x;
    logic            f;
    logic            busy;
    logic            sweep_valid;
    logic [N_IN-1:0] sweep_in;
    logic            sweep_out;
    logic            done;
    logic [N_IN:0]   ones_cnt;
`ifdef SWEEP_CHECK_EN
    logic [TT_W-1:0] exp_data;
    logic            mismatch;
    logic [N_IN-1:0] first_err;
    logic [TT_W-1:0] exp_m = '0;
`endif

    logic [TT_W-1:0] tt_m = '0;
    int errors = 0;
    int checks = 0;

    truth_table_sweeper #(.N_IN(N_IN)) dut (
        .clk         (clk),
        .reset       (reset),
        .tt_load     (tt_load),
        .tt_data     (tt_data),
        .start       (start),
        .x           (x),
        .f           (f),
        .busy        (busy),
        .sweep_valid (sweep_valid),
        .sweep_in    (sweep_in),
        .sweep_out   (sweep_out),
        .done        (done),
        .ones_cnt    (ones_cnt)
`ifdef SWEEP_CHECK_EN
        ,
        .exp_data    (exp_data),
        .mismatch    (mismatch),
        .first_err   (first_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic query(input logic [N_IN-1:0] xv);
        x = xv;
        step();
        check("f_query", f, tt_m[xv]);
    endtask

    task automatic load_tt(input logic [TT_W-1:0] d);
        tt_load = 1'b1;
        tt_data = d;
        step();
        tt_load = 1'b0;
        check("f_old_table_at_load", f, tt_m[x]);
        tt_m = d;
    endtask

    task automatic do_start(input logic with_load, input logic [TT_W-1:0] d);
        start   = 1'b1;
        tt_load = with_load;
        tt_data = d;
`ifdef SWEEP_CHECK_EN
        exp_data = exp_m;
`endif
        step();
        start   = 1'b0;
        tt_load = 1'b0;
        if (with_load) tt_m = d;
        check("busy_after_start", busy, 1);
        check("done_after_start", done, 0);
        check("valid_after_start", sweep_valid, 0);
`ifdef SWEEP_CHECK_EN
        check("mismatch_cleared_at_start", mismatch, 0);
`endif
    endtask

    // Expected stream: minterm i on the i-th cycle after start, with a running popcount.
    task automatic run_sweep(input int inject_at, input int abort_at);
        int ones;
`ifdef SWEEP_CHECK_EN
        int first;
        bit mm;
        first = 0;
        mm    = 1'b0;
`endif
        ones = 0;
        for (int i = 0; i < TT_W; i++) begin
            step();
            ones += int'(tt_m[i]);
            check("sweep_valid", sweep_valid, 1);
            check("sweep_in", sweep_in, i);
            check("sweep_out", sweep_out, tt_m[i]);
            check("ones_running", ones_cnt, ones);
            check("busy_in_sweep", busy, 1);
            check("done_in_sweep", done, 0);
            check("f_in_sweep", f, tt_m[x]);
`ifdef SWEEP_CHECK_EN
            if (tt_m[i] != exp_m[i]) begin
                if (!mm) first = i;
                mm = 1'b1;
            end
            check("mismatch", mismatch, mm);
            check("first_err", first_err, first);
`endif
            if (i == abort_at) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                tt_m  = '0;
                check("abort_busy", busy, 0);
                check("abort_valid", sweep_valid, 0);
                check("abort_done", done, 0);
                check("abort_ones", ones_cnt, 0);
                check("abort_f", f, 0);
                for (int k = 0; k < 20; k++) begin
                    step();
                    check("abort_no_done", done, 0);
                end
                return;
            end
            if (i == inject_at) begin
                tt_load = 1'b1;
                tt_data = ~tt_m;
                start   = 1'b1;
            end else if (i == inject_at + 1) begin
                tt_load = 1'b0;
                start   = 1'b0;
            end
        end
        step();
        check("done_pulse", done, 1);
        check("busy_at_done", busy, 0);
        check("valid_at_done", sweep_valid, 0);
        check("ones_final", ones_cnt, $countones(tt_m));
    endtask

    initial begin
        reset   = 1'b1;
        tt_load = 1'b0;
        tt_data = '0;
        start   = 1'b0;
        x       = N_IN'($urandom);
`ifdef SWEEP_CHECK_EN
        exp_data = '0;
`endif
        step();
        step();
        check("rst_f", f, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", sweep_valid, 0);
        check("rst_done", done, 0);
        check("rst_ones", ones_cnt, 0);
        reset = 1'b0;

        // Empty table sweep, then confirm done clears and ones_cnt holds.
        do_start(1'b0, '0);
        run_sweep(-1, -1);
        step();
        check("done_clears", done, 0);
        check("ones_held", ones_cnt, 0);

        // Directed table: load with x=0 so the load edge still sees the old table.
        x = 4'h0;
        load_tt(16'h5A93);
        query(4'h0);
        query(4'h2);
        query(4'hF);

        x = N_IN'($urandom);
        do_start(1'b0, '0);
        run_sweep(-1, -1);

        // Back-to-back start in the done cycle, loading all-ones; mid-sweep load/start ignored.
        do_start(1'b1, 16'hFFFF);
        run_sweep(3, -1);
        step();
        check("ones_held_16", ones_cnt, 16);
        do_start(1'b0, '0);
        run_sweep(-1, -1);

        // Reset while sweep_in=5 aborts and clears the table.
        do_start(1'b0, '0);
        run_sweep(-1, 5);
        query(N_IN'($urandom));
        query(N_IN'($urandom));

        for (int r = 0; r < 4; r++) begin
            load_tt(TT_W'($urandom));
            for (int q = 0; q < 4; q++) query(N_IN'($urandom));
`ifdef SWEEP_CHECK_EN
            exp_m = tt_m ^ ((r % 2 == 0) ? TT_W'(1 << $urandom_range(0, TT_W - 1)) : '0);
`endif
            x = N_IN'($urandom);
            do_start(1'b0, '0);
            run_sweep(-1, -1);
        end

`ifdef SWEEP_CHECK_EN
        load_tt(16'h5A93);
        exp_m = 16'h5A83;
        do_start(1'b0, '0);
        run_sweep(-1, -1);
        check("first_err_at_done", first_err, 4);
        check("mismatch_at_done", mismatch, 1);
        exp_m = 16'h5A93;
        do_start(1'b0, '0);
        run_sweep(-1, -1);
        check("mismatch_clean", mismatch, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
